// File: rtl/encoder_speed.sv
// Quadrature encoder front end: x4 decode of A/B, signed step count per
// PERIOD-clock window, published as 8-bit magnitude + direction with a strobe.
module encoder_speed #(
  parameter int PERIOD = 50000,
  parameter int ACC_W  = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       EncA,
  input  logic       EncB,
  input  logic       Invert,
  output logic [7:0] Current,
  output logic       Dir_C,
  output logic       Valid,
  output logic       Sat,
  output logic       Err
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic signed [ACC_W:0] SUM_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;

  logic a_s1, a_s2, b_s1, b_s2;
  logic [1:0] prev;
  logic [1:0] cur;
  logic primed;
  logic [CNT_W-1:0] cnt;
  logic signed [ACC_W-1:0] acc;
  logic win_err;

  logic signed [1:0] raw_delta;
  logic signed [1:0] delta;
  logic illegal;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] delta_ext;
  logic [ACC_W-1:0] acc_abs;
  logic acc_over;
  logic acc_pos;
  logic acc_neg;
  logic [7:0] mag;

  assign cur = {a_s2, b_s2};

  // Gray sequence 00->10->11->01->00 ({A,B}) is forward; a two-bit jump is illegal.
  always_comb begin
    raw_delta = 2'sd0;
    illegal   = 1'b0;
    if (primed) begin
      case ({prev, cur})
        4'b0010, 4'b1011, 4'b1101, 4'b0100: raw_delta = 2'sd1;
        4'b0001, 4'b0111, 4'b1110, 4'b1000: raw_delta = -2'sd1;
        4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
        default: raw_delta = 2'sd0;
      endcase
    end
    delta = Invert ? -raw_delta : raw_delta;
  end

  // One extra bit of headroom so the clamp to +/-(2^(ACC_W-1)-1) never sees a wrap.
  assign sum       = {acc[ACC_W-1], acc} + {{(ACC_W-1){delta[1]}}, delta};
  assign acc_next  = (sum > SUM_MAX) ? SUM_MAX[ACC_W-1:0] :
                     (sum < SUM_MIN) ? SUM_MIN[ACC_W-1:0] : sum[ACC_W-1:0];
  assign delta_ext = {{(ACC_W-2){delta[1]}}, delta};

  assign acc_neg  = acc[ACC_W-1];
  assign acc_pos  = !acc[ACC_W-1] && (acc != '0);
  assign acc_abs  = acc_neg ? -acc : acc;
  assign acc_over = (acc_abs > ACC_W'(8'hFF));
  assign mag      = acc_over ? 8'hFF : acc_abs[7:0];

  // Valid is a one-cycle strobe with no ready: Current/Dir_C/Sat/Err are
  // updated in the same cycle and then held until the next strobe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_s1    <= 1'b0;
      a_s2    <= 1'b0;
      b_s1    <= 1'b0;
      b_s2    <= 1'b0;
      prev    <= 2'b00;
      primed  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      win_err <= 1'b0;
      Current <= 8'd0;
      Dir_C   <= 1'b0;
      Valid   <= 1'b0;
      Sat     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      a_s1   <= EncA;
      a_s2   <= a_s1;
      b_s1   <= EncB;
      b_s2   <= b_s1;
      prev   <= cur;
      primed <= 1'b1;
      Valid  <= 1'b0;
      if (cnt == LAST) begin
        cnt     <= '0;
        Valid   <= 1'b1;
        Current <= mag;
        Sat     <= acc_over;
        Err     <= win_err;
        if (acc_pos) begin
          Dir_C <= 1'b1;
        end else if (acc_neg) begin
          Dir_C <= 1'b0;
        end
        // The step decoded on the wrap cycle opens the next window.
        acc     <= delta_ext;
        win_err <= illegal;
      end else begin
        cnt     <= cnt + 1'b1;
        acc     <= acc_next;
        win_err <= win_err | illegal;
      end
    end
  end

endmodule
